// File: rtl/bsg_mem_1rw_sync_mask_write_var_client.sv
// Request-side controller for a 1rw synchronous masked-write memory: read data 1 cycle after accept,
// 2-entry response buffer; ready_o is a registered credit so consumer stalls never drop read data.
module bsg_mem_1rw_sync_mask_write_var_client
  #(parameter int width_p       = 32
   ,parameter int mask_width_p  = 8
   ,parameter int els_p         = 16
   ,parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
   ,parameter int mask_els_lp   = width_p / mask_width_p
   )
  (input  logic                     clk_i
  ,input  logic                     reset_i

  ,input  logic                     v_i
  ,input  logic                     w_i
  ,input  logic [addr_width_lp-1:0] addr_i
  ,input  logic [width_p-1:0]       data_i
  ,input  logic [mask_els_lp-1:0]   w_mask_i
  ,output logic                     ready_o

  ,output logic                     mem_v_o
  ,output logic                     mem_w_o
  ,output logic [addr_width_lp-1:0] mem_addr_o
  ,output logic [width_p-1:0]       mem_data_o
  ,output logic [width_p-1:0]       mem_w_mask_o
  ,input  logic [width_p-1:0]       mem_data_i

  ,output logic                     v_o
  ,output logic [width_p-1:0]       data_o
  ,input  logic                     yumi_i
  );

  logic               accept;
  logic               inflight_r;
  logic [1:0]         occ_r, occ_n;
  logic               wptr_r, rptr_r;
  logic               buf_empty, enq, deq;
  logic [width_p-1:0] buf_r [2];
  logic [width_p-1:0] mask_exp;

  for (genvar j = 0; j < width_p; j++) begin : g_mask
    assign mask_exp[j] = w_mask_i[j/mask_width_p];
  end

  // Credit counts both buffered words and the read whose data lands next cycle.
  assign ready_o = ~reset_i & ((occ_r + {1'b0, inflight_r}) < 2'd2);
  assign accept  = v_i & ready_o;

  assign mem_v_o      = accept;
  assign mem_w_o      = accept & w_i;
  assign mem_addr_o   = addr_i;
  assign mem_data_o   = data_i;
  assign mem_w_mask_o = w_i ? mask_exp : '0;

  assign buf_empty = (occ_r == 2'd0);
  assign v_o       = ~reset_i & (inflight_r | ~buf_empty);
  assign data_o    = buf_empty ? mem_data_i : buf_r[rptr_r];

  // Arriving data bypasses only when the buffer is empty and is taken immediately.
  assign enq   = inflight_r & ~(buf_empty & yumi_i);
  assign deq   = yumi_i & ~buf_empty;
  assign occ_n = occ_r + {1'b0, enq} - {1'b0, deq};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_r <= 1'b0;
      occ_r      <= 2'd0;
      wptr_r     <= 1'b0;
      rptr_r     <= 1'b0;
    end else begin
      inflight_r <= accept & ~w_i;
      occ_r      <= occ_n;
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) buf_r[wptr_r] <= mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    assert (width_p % mask_width_p == 0)
      else $error("width_p must be a multiple of mask_width_p");
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o is low");
    end
  end

endmodule
